// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage for the RV32I core.
// Takes the ALU result as the effective address and rs2 as store data, runs one
// request/ready bus transaction per load/store, stalls the core while it is in
// flight, and returns the extended load value to the write-back mux.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_data_mem,
  output logic        o_stall,
  output logic        o_fault,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;

  // Transaction registers, loaded once when a legal request is accepted.
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] data_mem_q;

  logic        req_any;
  logic        legal;
  logic        accept;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req_any = i_mem_read | i_mem_write;
  assign accept  = (state == IDLE) && req_any && legal;

  // Alignment and funct3 legality; a store takes priority when both requests are up.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    legal = 1'b0;
    if (i_mem_write) begin
      case (i_funct3)
        3'd0:    legal = 1'b1;
        3'd1:    legal = ~i_addr[0];
        3'd2:    legal = (i_addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        3'd0, 3'd4: legal = 1'b1;
        3'd1, 3'd5: legal = ~i_addr[0];
        3'd2:       legal = (i_addr[1:0] == 2'b00);
        default:    legal = 1'b0;
      endcase
    end
  end

  // Store lane steering: byte enables and replicated write data. Loads carry no lanes.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'd0: begin
          be_d    = 4'b0001 << i_addr[1:0];
          wdata_d = {4{i_wdata[7:0]}};
        end
        2'd1: begin
          be_d    = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{i_wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = i_wdata;
        end
      endcase
    end
  end

  // Load extraction from the returned bus word using the captured offset and size.
  always_comb begin
    byte_sel = i_bus_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'h0, byte_sel};
      3'd5:    load_ext = {16'h0, half_sel};
      default: load_ext = i_bus_rdata;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, wait for ready in REQ, one retire cycle in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (i_bus_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at acceptance so bus outputs stay stable through wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      be_q     <= 4'b0000;
    end else if (accept) begin
      addr_q   <= {i_addr[31:2], 2'b00};
      we_q     <= i_mem_write;
      funct3_q <= i_funct3;
      off_q    <= i_addr[1:0];
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  // Load result register: updated only when a read completes in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      data_mem_q <= 32'h0;
    else if (state == REQ && i_bus_ready && !we_q) data_mem_q <= load_ext;
  end

  // Bus outputs are forced low outside REQ, so reset drops the request at once.
  assign o_bus_req   = (state == REQ);
  assign o_bus_we    = o_bus_req & we_q;
  assign o_bus_addr  = o_bus_req ? addr_q  : 32'h0;
  assign o_bus_wdata = o_bus_req ? wdata_q : 32'h0;
  assign o_bus_be    = o_bus_req ? be_q    : 4'b0000;

  assign o_stall    = (state == REQ) || accept;
  assign o_fault    = (state == IDLE) && req_any && !legal;
  assign o_data_mem = data_mem_q;

endmodule
